rf_div_unit: RTL and testbench
==============================

Name: rf_div_unit

Overview:
Multi-cycle RISC-V M-extension divide unit (DIV, DIVU, REM, REMU) that sits on the write-back side of the 32x32 register file. It takes rs1/rs2 operand values already read from the register file (rd1/rd2) and computes the result with a radix-2 restoring iteration. It then drives the register file write port (we3/wa3/wd3) for exactly one cycle. The core issues a start pulse and stalls on busy.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN
AW, 5, register address width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request pulse; accepted only when busy=0
op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
rs1_val  in  XLEN  dividend (from regfile rd1)
rs2_val  in  XLEN  divisor (from regfile rd2)
rd_addr  in  AW  destination register
busy  out  1  high from accepting edge until WB cycle ends
done  out  1  one-cycle completion pulse (coincident with WB)
we3  out  1  regfile write enable
wa3  out  AW  regfile write address
wd3  out  XLEN  regfile write data

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous and active-low.
- Reset: state=IDLE. busy, done, we3 = 0. wa3 = 0, wd3 = 0. Counter and all datapath registers = 0.
- Reset mid-operation: the operation is aborted immediately. No write occurs.
- Registered outputs: all outputs come from flops; no combinational path from any input to any output.
- States: IDLE, ITER, FIXUP, WB.
- IDLE: on an edge with start=1, latch op, rd_addr and operands, and set busy=1. Next state depends on the operands:
  - rs2_val==0, or signed overflow (op DIV/REM, rs1=0x80000000, rs2=0xFFFFFFFF): go to WB directly, with the special result loaded.
  - Otherwise: go to ITER with count=0.
- Operand conditioning (at accept): for signed ops, store |rs1| and |rs2|, plus neg_q = sign1 XOR sign2 and neg_r = sign1. For unsigned ops, both flags are 0.
- ITER: each edge shifts the {rem, quo} pair left by 1. It subtracts the divisor from rem. If the difference is nonnegative, rem takes the difference and the quo LSB is 1; otherwise rem is kept and the LSB is 0. count increments; the edge with count==XLEN-1 goes to FIXUP.
- FIXUP: negate quo if neg_q and negate rem if neg_r. Select quo for DIV/DIVU or rem for REM/REMU into wd3. Go to WB.
- WB: one cycle with done=1 and wa3=rd_addr. we3=1 only if rd_addr!=0; writes to x0 are suppressed but done still pulses. The next edge goes to IDLE with busy=0, done=0, we3=0. wa3 and wd3 hold their values.
- Latency: normal ops take 34 cycles; we3/done are high in the cycle after the 34th edge counting the accepting edge as 1. Special cases take 1 cycle (high in the cycle after the accepting edge).
- Special results:
  - Divide by zero: quotient = all ones (DIV and DIVU); remainder = rs1_val.
  - Overflow: quotient = 0x80000000; remainder = 0.
- start while busy=1, including the WB cycle, is ignored with no side effects. Back-to-back throughput is one op per 35 cycles minimum.
- Operand inputs need only be valid on the accepting edge.
- Arithmetic: all internal arithmetic is unsigned XLEN+1 bit, and the subtraction borrow decides the quotient bit. Negation is two's complement modulo 2^XLEN.

Decomposition:
- Package div_pkg holds:
  - XLEN and AW defaults
  - op encoding typedef (DIV, DIVU, REM, REMU)
  - state enum (IDLE, ITER, FIXUP, WB)
  - constants DIV_ZERO_Q = all ones and INT_MIN = 0x80000000
- One sub-module is natural: div_step, a combinational single restoring iteration taking (rem, quo, divisor) and returning (rem', quo'). It keeps the FSM file small and is unit-testable on its own.

Test Plan:
- DIV 100/7, rd=5 -> we3=1, wa3=5, wd3=14, asserted exactly 34 cycles after accept. Then REM 100/7 -> wd3=2.
- REM -7/2 (0xFFFFFFF9, 2) -> wd3=0xFFFFFFFF (-1). DIV -7/2 -> wd3=0xFFFFFFFD (-3). DIVU 0xFFFFFFFF/2 -> 0x7FFFFFFF.
- Divide by zero: DIV 1234/0 -> wd3=0xFFFFFFFF. REMU 1234/0 -> wd3=1234. Both write 1 cycle after accept.
- Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM of the same operands -> 0. 1-cycle latency.
- rd_addr=0, DIV 9/3 -> done pulses at cycle 34 with we3=0. start pulsed at cycle 10 of a busy op -> ignored, and the original result is unchanged.
- rst_n low at cycle 15 of an op -> busy/done/we3 fall asynchronously. No write follows. A fresh start after release completes normally.

Source files
------------

// File: rtl/div_pkg.sv
// div_pkg: shared widths, opcode/state encodings and special-result constants for the divide unit.
package div_pkg;
    localparam int XLEN = 32;
    localparam int AW   = 5;

    typedef enum logic [1:0] {OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11} op_e;
    typedef enum logic [1:0] {IDLE, ITER, FIXUP, WB} state_e;

    localparam logic [XLEN-1:0] DIV_ZERO_Q = '1;
    localparam logic [XLEN-1:0] INT_MIN    = {1'b1, {(XLEN-1){1'b0}}};
endpackage

// File: rtl/div_step.sv
// div_step: one combinational radix-2 restoring iteration on the {rem, quo} pair.
module div_step #(
    parameter int XLEN = div_pkg::XLEN
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] dvs_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);
    logic [XLEN:0] sh;
    logic          borrow;

    // Partial remainder stays below the divisor, so the shifted value needs one extra bit.
    assign sh     = {rem_i, quo_i[XLEN-1]};
    assign borrow = sh < {1'b0, dvs_i};
    assign rem_o  = borrow ? sh[XLEN-1:0] : sh[XLEN-1:0] - dvs_i;
    assign quo_o  = {quo_i[XLEN-2:0], ~borrow};
endmodule

// File: rtl/rf_div_unit.sv
// rf_div_unit: multi-cycle RV32M DIV/DIVU/REM/REMU unit writing its result to the register file port 3.
module rf_div_unit
    import div_pkg::*;
#(
    parameter int XLEN = div_pkg::XLEN,
    parameter int AW   = div_pkg::AW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [AW-1:0]   rd_addr,
    output logic            busy,
    output logic            done,
    output logic            we3,
    output logic [AW-1:0]   wa3,
    output logic [XLEN-1:0] wd3
);
    localparam int CW = $clog2(XLEN);

    state_e          state_q, state_d;
    op_e             op_q, op_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   rd_q, rd_d, wa_q, wa_d;
    logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, wd_q, wd_d;
    logic            negq_q, negq_d, negr_q, negr_d;
    logic            busy_q, busy_d, done_q, done_d, we_q, we_d;
    logic [XLEN-1:0] step_rem, step_quo, a1, a2, spec_res, fix_res;
    logic            accept, sgn, s1, s2, special;

    assign accept   = state_q == IDLE && start;
    assign sgn      = ~op[0];
    assign s1       = sgn & rs1_val[XLEN-1];
    assign s2       = sgn & rs2_val[XLEN-1];
    assign a1       = s1 ? ~rs1_val + 1'b1 : rs1_val;
    assign a2       = s2 ? ~rs2_val + 1'b1 : rs2_val;
    assign special  = rs2_val == '0 || (sgn && rs1_val == INT_MIN && rs2_val == '1);
    assign spec_res = rs2_val == '0 ? (op[1] ? rs1_val : DIV_ZERO_Q) : (op[1] ? '0 : INT_MIN);
    assign fix_res  = op_q inside {OP_REM, OP_REMU} ? (negr_q ? ~rem_q + 1'b1 : rem_q)
                                                    : (negq_q ? ~quo_q + 1'b1 : quo_q);

    div_step #(.XLEN(XLEN)) u_step (
        .rem_i(rem_q),
        .quo_i(quo_q),
        .dvs_i(dvs_q),
        .rem_o(step_rem),
        .quo_o(step_quo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? (special ? WB : ITER) : IDLE;
            ITER:    state_d = cnt_q == CW'(XLEN-1) ? FIXUP : ITER;
            FIXUP:   state_d = WB;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        op_d   = accept ? op_e'(op) : op_q;
        rd_d   = accept ? rd_addr : rd_q;
        negq_d = accept ? s1 ^ s2 : negq_q;
        negr_d = accept ? s1 : negr_q;
        dvs_d  = accept ? a2 : dvs_q;
        rem_d  = accept ? '0 : state_q == ITER ? step_rem : rem_q;
        quo_d  = accept ? a1 : state_q == ITER ? step_quo : quo_q;
        cnt_d  = accept ? '0 : state_q == ITER ? cnt_q + 1'b1 : cnt_q;
        wd_d   = accept && special ? spec_res : state_q == FIXUP ? fix_res : wd_q;
        busy_d = state_d != IDLE;
        done_d = state_d == WB;
        we_d   = state_d == WB && rd_d != '0;
        wa_d   = state_d == WB ? rd_d : wa_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= OP_DIV;
            rd_q   <= '0;
            negq_q <= 1'b0;
            negr_q <= 1'b0;
            dvs_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            wd_q   <= '0;
            wa_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            we_q   <= 1'b0;
        end else begin
            op_q   <= op_d;
            rd_q   <= rd_d;
            negq_q <= negq_d;
            negr_q <= negr_d;
            dvs_q  <= dvs_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            cnt_q  <= cnt_d;
            wd_q   <= wd_d;
            wa_q   <= wa_d;
            busy_q <= busy_d;
            done_q <= done_d;
            we_q   <= we_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign we3  = we_q;
    assign wa3  = wa_q;
    assign wd3  = wd_q;
endmodule

// File: tb/tb_rf_div_unit.sv
// tb_rf_div_unit: directed and random checks of rf_div_unit against an integer-arithmetic reference.
module tb_rf_div_unit;
    logic        clk = 1'b0;
    logic        rst_n, start, busy, done, we3;
    logic [1:0]  op;
    logic [31:0] rs1, rs2, wd3;
    logic [4:0]  rd, wa3;
    int          n_chk = 0, n_fail = 0;

    rf_div_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs1_val(rs1), .rs2_val(rs2),
        .rd_addr(rd), .busy(busy), .done(done), .we3(we3), .wa3(wa3), .wd3(wd3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: RISC-V semantics from plain 64-bit integer division (truncating toward zero).
    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        if (b == 0) return o[1] ? a : 32'hFFFF_FFFF;
        case (o)
            2'd0:    return 32'(sa / sb);
            2'd1:    return a / b;
            2'd2:    return 32'(sa % sb);
            default: return a % b;
        endcase
    endfunction

    task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] r, input bit inject);
        int          lat;
        int          exp_lat;
        logic [31:0] exp_wd;
        exp_wd  = model(o, a, b);
        exp_lat = (b == 0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 34;
        @(negedge clk);
        op = o; rs1 = a; rs2 = b; rd = r; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; rs1 = $urandom; rs2 = $urandom;
        lat = 1;
        chk("busy_after_accept", busy, 1);
        while (!done && lat < 60) begin
            if (inject && lat == 10) begin
                start = 1'b1; op = 2'($urandom); rs1 = $urandom; rs2 = $urandom; rd = 5'($urandom);
            end else start = 1'b0;
            @(posedge clk);
            #1 lat++;
        end
        start = 1'b0;
        chk("latency", lat, exp_lat);
        chk("done_pulse", done, 1);
        chk("busy_in_wb", busy, 1);
        chk("we3", we3, r != 0);
        chk("wa3", wa3, r);
        chk("wd3", wd3, exp_wd);
        if (inject) begin
            start = 1'b1; op = 2'($urandom); rs1 = $urandom; rs2 = 0; rd = 5'($urandom);
        end
        @(posedge clk);
        #1 start = 1'b0;
        chk("busy_after_wb", busy, 0);
        chk("done_after_wb", done, 0);
        chk("we3_after_wb", we3, 0);
        chk("wa3_hold", wa3, r);
        chk("wd3_hold", wd3, exp_wd);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          seen_we;
        logic [1:0]  o;
        logic [31:0] a, b;
        int          sel;
        rst_n = 1'b0; start = 1'b0; op = 0; rs1 = 0; rs2 = 0; rd = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_we3", we3, 0);
        chk("rst_wa3", wa3, 0);
        chk("rst_wd3", wd3, 0);
        rst_n = 1'b1;

        run(2'd0, 100, 7, 5, 0);
        run(2'd2, 100, 7, 5, 0);
        run(2'd2, 32'hFFFF_FFF9, 2, 3, 0);
        run(2'd0, 32'hFFFF_FFF9, 2, 3, 0);
        run(2'd1, 32'hFFFF_FFFF, 2, 4, 0);
        run(2'd0, 1234, 0, 6, 0);
        run(2'd3, 1234, 0, 6, 0);
        run(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 8, 0);
        run(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 8, 0);
        run(2'd0, 9, 3, 0, 0);
        run(2'd0, 1000, 13, 9, 1);
        run(2'd2, 32'h8000_0000, 1, 10, 1);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        op = 2'd0; rs1 = 1000; rs2 = 3; rd = 7; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (14) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_we3", we3, 0);
        seen_we = 0;
        repeat (3) begin
            @(negedge clk);
            seen_we |= we3;
        end
        rst_n = 1'b1;
        repeat (40) begin
            @(negedge clk);
            seen_we |= we3 | done;
        end
        chk("no_write_after_abort", seen_we, 0);
        run(2'd0, 1000, 3, 7, 0);

        for (int i = 0; i < 40; i++) begin
            o   = 2'($urandom);
            a   = $urandom;
            sel = $urandom_range(0, 7);
            b   = sel == 0 ? 0 : sel < 3 ? $urandom_range(1, 100) : $urandom;
            if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            run(o, a, b, 5'($urandom), i % 5 == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
